// File: rtl/imem_loader.sv
// Streams bytes into little-endian 32-bit words, writes each one into the next instruction slot,
// and then reads the slot back to verify it. The core is held in reset while a load is in progress.
module imem_loader #(
    parameter int DEPTH = 16,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic [31:0]      la_instruction_input,
    output logic [SEL_W-1:0] la_instruction_select,
    output logic             la_instruction_write,
    input  logic [31:0]      la_instruction_read,
    output logic             core_rst_n,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [SEL_W-1:0] error_index,
    output logic [SEL_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_VERIFY,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(DEPTH - 1);

    state_t           state_q;
    logic [1:0]       byte_cnt_q;
    logic [23:0]      word_q;
    logic             byte_ready_q;
    logic [31:0]      input_q;
    logic [SEL_W-1:0] sel_q;
    logic             write_q;
    logic             core_rst_n_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;
    logic [SEL_W-1:0] error_index_q;
    logic [SEL_W:0]   words_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            byte_cnt_q    <= 2'd0;
            word_q        <= 24'd0;
            byte_ready_q  <= 1'b0;
            input_q       <= 32'd0;
            sel_q         <= '0;
            write_q       <= 1'b0;
            core_rst_n_q  <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            error_index_q <= '0;
            words_q       <= '0;
        end else begin
            write_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_q      <= S_COLLECT;
                        sel_q        <= '0;
                        byte_cnt_q   <= 2'd0;
                        words_q      <= '0;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                        byte_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                        core_rst_n_q <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (byte_valid && byte_ready_q) begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        case (byte_cnt_q)
                            2'd0: word_q[7:0]   <= byte_in;
                            2'd1: word_q[15:8]  <= byte_in;
                            2'd2: word_q[23:16] <= byte_in;
                            default: begin
                                // The fourth byte goes directly into the write data, so WRITE can follow immediately.
                                input_q      <= {byte_in, word_q};
                                write_q      <= 1'b1;
                                byte_ready_q <= 1'b0;
                                state_q      <= S_WRITE;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    state_q <= S_VERIFY;
                end
                S_VERIFY: begin
                    if (la_instruction_read != input_q) begin
                        state_q       <= S_ERROR;
                        error_q       <= 1'b1;
                        error_index_q <= sel_q;
                        busy_q        <= 1'b0;
                        core_rst_n_q  <= 1'b1;
                    end else begin
                        words_q <= words_q + 1'b1;
                        if (sel_q == LAST_IDX) begin
                            state_q      <= S_DONE;
                            done_q       <= 1'b1;
                            busy_q       <= 1'b0;
                            core_rst_n_q <= 1'b1;
                        end else begin
                            sel_q        <= sel_q + 1'b1;
                            byte_cnt_q   <= 2'd0;
                            byte_ready_q <= 1'b1;
                            state_q      <= S_COLLECT;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign byte_ready            = byte_ready_q;
    assign la_instruction_input  = input_q;
    assign la_instruction_select = sel_q;
    assign la_instruction_write  = write_q;
    assign core_rst_n            = core_rst_n_q;
    assign busy                  = busy_q;
    assign done                  = done_q;
    assign error                 = error_q;
    assign error_index           = error_index_q;
    assign words_loaded          = words_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that acts as the writer for the instruction memory's logic-analyzer port. It receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written into the next instruction slot through `la_instruction_input`/`la_instruction_select`/`la_instruction_write`, then read back through `la_instruction_read` and compared. The CPU core is held in reset for the whole load so it never fetches a partially written program.

## Interface
Parameters:
- `DEPTH`, 16, number of instruction slots loaded per program (must equal memory word count)
- `SEL_W`, 4, width of slot select; 2**SEL_W >= DEPTH

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  begin a load; sampled only in IDLE, DONE, ERROR
- `byte_in`  in  8  next program byte
- `byte_valid`  in  1  byte_in valid
- `byte_ready`  out  1  loader accepts byte this cycle
- `la_instruction_input`  out  32  word to write
- `la_instruction_select`  out  SEL_W  slot index (write and readback)
- `la_instruction_write`  out  1  write strobe, one cycle per word
- `la_instruction_read`  in  32  combinational readback of selected slot
- `core_rst_n`  out  1  low while loading; ANDed with rst_n at top for the core only (never the memory's reset, which would restore the default program)
- `busy`  out  1  load in progress
- `done`  out  1  all DEPTH words written and verified
- `error`  out  1  readback mismatch
- `error_index`  out  SEL_W  slot of first mismatch
- `words_loaded`  out  SEL_W+1  count of verified words

## Operation
- All outputs registered. Reset values:
  - byte_ready, la_instruction_write, busy, done, error = 0
  - la_instruction_input, la_instruction_select, error_index, words_loaded = 0
  - core_rst_n = 1
  - state IDLE, byte count 0
- IDLE: on `start` -> COLLECT. Clear index, byte count, words_loaded, done, error.
- COLLECT:
  - byte_ready=1.
  - Accept on byte_valid&byte_ready. Byte k (0..3) goes into bits [8k+7:8k].
  - Accepting the 4th byte -> WRITE.
- WRITE:
  - la_instruction_write=1 for exactly this cycle, with select=index and input=assembled word.
  - byte_ready=0 -> VERIFY.
- VERIFY:
  - byte_ready=0; select and input held.
  - la_instruction_read != assembled word -> ERROR, with error_index=index.
  - Match: words_loaded+1. If index==DEPTH-1 -> DONE, else index+1, byte count 0 -> COLLECT.
- DONE: done=1 held. `start` -> COLLECT (restart, clears as in IDLE).
- ERROR: error=1 held, error_index held. `start` -> COLLECT.
- busy=1 and core_rst_n=0 exactly in COLLECT, WRITE, VERIFY.
- `start` in COLLECT/WRITE/VERIFY is ignored.
- Index never wraps: a load always ends at DEPTH-1.
- No bytes are accepted in DONE or ERROR.
- rst_n low mid-load:
  - Next edge returns everything to reset values and the partial word is discarded.
  - Slots already written keep their contents.

## Timing
- `start` sampled at edge N -> COLLECT from N+1; byte_ready high in cycle N+1.
- With byte_valid held high, each word takes 6 cycles: 4 accept, 1 WRITE, 1 VERIFY.
- Full load takes 96 cycles after the start edge. done and busy=0 are visible the cycle after the last VERIFY; core_rst_n returns high in the same cycle.
- byte_ready deasserts the cycle after the 4th byte is accepted and stays low for 2 cycles.
- Readback compare happens in the cycle after the write edge. The memory must show the written value combinationally by then.
- Gaps in byte_valid only stretch COLLECT; they have no other effect.

## Test plan
- Continuous load: word 0 bytes 93,00,C0,03 and 15 further words, start at cycle 0.
  - Slot 0 written with 0x03C00093; one write strobe per slot.
  - done=1 at cycle 97; words_loaded=16; core_rst_n low during cycles 1..96.
- Backpressure: byte_valid toggles randomly and a byte is presented during WRITE/VERIFY.
  - Byte not consumed until COLLECT; all words assemble correctly and in order.
- Mismatch: memory model corrupts slot 5 readback (bit 0 flipped).
  - error=1, error_index=5, words_loaded=5, done=0, busy=0, core_rst_n=1.
  - No write to slot 6.
- Start handling: `start` pulsed during word 2 -> ignored, load completes normally.
  - `start` in DONE -> done clears and index restarts at 0.
- Reset mid-word: rst_n low for 1 cycle after 2 bytes of word 3.
  - All outputs return to reset values.
  - Next start writes the first 4 new bytes to slot 0; slots 0..2 keep their prior values until overwritten.
